// File: rtl/pc_trap_unit.sv
// Program-counter sequencer: next-PC selection, memory-stall hold, bus-timeout
// trap and external interrupt entry/return with a saved return PC.
module pc_trap_unit #(
  parameter int unsigned NBITS        = 8,
  parameter int unsigned PC_STEP      = 4,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int unsigned TRAP_VECTOR  = 'h80,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Branch,
  input  logic             ju,
  input  logic             jr,
  input  logic             ret,
  input  logic [2:0]       funct3,
  input  logic [NBITS-1:0] IMM,
  input  logic [NBITS-1:0] PCReg,
  input  logic             Zero,
  input  logic             Neg,
  input  logic             Carry,
  input  logic             busy,
  input  logic             interrupt,
  output logic [NBITS-1:0] pc,
  output logic [NBITS-1:0] pc_next,
  output logic [NBITS-1:0] pclink,
  output logic             link,
  output logic             PCSrc,
  output logic             stall,
  output logic             abort,
  output logic [NBITS-1:0] sepc,
  output logic             in_trap,
  output logic [1:0]       cause
);

  localparam int unsigned CW = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);
  localparam logic [NBITS-1:0] RST_PC   = NBITS'(RESET_VECTOR);
  localparam logic [NBITS-1:0] TRAP_PC  = NBITS'(TRAP_VECTOR);
  localparam logic [NBITS-1:0] STEP     = NBITS'(PC_STEP);
  localparam logic [CW-1:0]    CNT_LAST = CW'(BUSY_TIMEOUT - 1);

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_IRQ  = 2'd1;
  localparam logic [1:0] CAUSE_BUS  = 2'd2;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] pc_q;
  logic [NBITS-1:0] sepc_q, sepc_d;
  logic             in_trap_q, in_trap_d;
  logic [1:0]       cause_q, cause_d;
  logic             pending_q, pending_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             taken;
  logic [NBITS-1:0] rel_tgt, jr_sum, ppc;
  logic             nonseq;
  logic [CW-1:0]    cnt_cur;
  logic             timeout, irq_take;

  // Branch condition from the ALU flags of rs1-rs2
  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = Neg;
      3'b101:  taken = ~Neg;
      3'b110:  taken = Carry;
      3'b111:  taken = ~Carry;
      default: taken = 1'b0;
    endcase
  end

  // Request-priority target selection
  always_comb begin
    rel_tgt = pc_q + IMM;
    jr_sum  = PCReg + IMM;
    ppc     = pc_q + STEP;
    nonseq  = 1'b1;
    if (ret)                 ppc = sepc_q;
    else if (jr)             ppc = {jr_sum[NBITS-1:1], 1'b0};
    else if (ju)             ppc = rel_tgt;
    else if (Branch && taken) ppc = rel_tgt;
    else                     nonseq = 1'b0;
  end

  // The busy-cycle count is only meaningful while already stalled
  assign cnt_cur  = (state_q == STALL) ? cnt_q : '0;
  assign timeout  = busy && (cnt_cur == CNT_LAST);
  assign irq_take = !busy && !in_trap_q && (pending_q || interrupt);

  // Next-state and combinational outputs
  always_comb begin
    state_d   = RUN;
    cnt_d     = '0;
    sepc_d    = sepc_q;
    in_trap_d = in_trap_q;
    cause_d   = cause_q;
    pending_d = pending_q | interrupt;
    pc_next   = ppc;
    link      = ju | jr;
    PCSrc     = nonseq;
    stall     = 1'b0;
    abort     = 1'b0;

    if (timeout) begin
      pc_next   = TRAP_PC;
      link      = 1'b0;
      PCSrc     = 1'b0;
      abort     = 1'b1;
      sepc_d    = pc_q;
      in_trap_d = 1'b1;
      cause_d   = CAUSE_BUS;
    end else if (busy) begin
      state_d = STALL;
      cnt_d   = cnt_cur + CW'(1);
      pc_next = pc_q;
      link    = 1'b0;
      PCSrc   = 1'b0;
      stall   = 1'b1;
    end else if (irq_take) begin
      pc_next   = TRAP_PC;
      sepc_d    = ppc;
      in_trap_d = 1'b1;
      cause_d   = CAUSE_IRQ;
      pending_d = 1'b0;
    end else if (ret) begin
      in_trap_d = 1'b0;
      cause_d   = CAUSE_NONE;
    end

    if (!reset) begin
      pc_next = RST_PC;
      link    = 1'b0;
      PCSrc   = 1'b0;
      abort   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      pc_q      <= RST_PC;
      sepc_q    <= '0;
      in_trap_q <= 1'b0;
      cause_q   <= CAUSE_NONE;
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_next;
      sepc_q    <= sepc_d;
      in_trap_q <= in_trap_d;
      cause_q   <= cause_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pc      = pc_q;
  assign pclink  = pc_q + STEP;
  assign sepc    = sepc_q;
  assign in_trap = in_trap_q;
  assign cause   = cause_q;

endmodule

// File: tb/tb_pc_trap_unit.sv
// Bench for pc_trap_unit: directed vector table, a reset-mid-stall sequence,
// then randomized traffic against a behavioural model of the sequencer.
module tb_pc_trap_unit;

  localparam int unsigned TO = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       Branch, ju, jr, ret, Zero, Neg, Carry, busy, interrupt;
  logic [2:0] funct3;
  logic [7:0] IMM, PCReg;
  logic [7:0] pc, pc_next, pclink, sepc;
  logic       link, PCSrc, stall, abort, in_trap;
  logic [1:0] cause;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pc_trap_unit #(
    .NBITS(8), .PC_STEP(4), .RESET_VECTOR(0), .TRAP_VECTOR('h80), .BUSY_TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .Branch(Branch), .ju(ju), .jr(jr), .ret(ret),
    .funct3(funct3), .IMM(IMM), .PCReg(PCReg), .Zero(Zero), .Neg(Neg), .Carry(Carry),
    .busy(busy), .interrupt(interrupt), .pc(pc), .pc_next(pc_next), .pclink(pclink),
    .link(link), .PCSrc(PCSrc), .stall(stall), .abort(abort), .sepc(sepc),
    .in_trap(in_trap), .cause(cause)
  );

  typedef struct {
    logic [3:0] req;    // {Branch, ju, jr, ret}
    logic [2:0] f3;
    logic [7:0] imm;
    logic [7:0] pcreg;
    logic [2:0] flg;    // {Zero, Neg, Carry}
    logic [1:0] ctl;    // {busy, interrupt}
    logic [7:0] e_pcn;
    logic [3:0] e_out;  // {link, PCSrc, stall, abort}
    logic [7:0] e_pc;
    logic [7:0] e_sepc;
    logic       e_trap;
    logic [1:0] e_cause;
  } vec_t;

  vec_t vt [0:30];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic [2:0] f3, input logic [7:0] imm,
                       input logic [7:0] pcr, input logic [2:0] flg, input logic [1:0] ctl);
    {Branch, ju, jr, ret} = req;
    funct3 = f3;
    IMM    = imm;
    PCReg  = pcr;
    {Zero, Neg, Carry}  = flg;
    {busy, interrupt}   = ctl;
  endtask

  // Behavioural model state
  logic [7:0] m_pc, m_sepc;
  logic       m_trap, m_pend;
  logic [1:0] m_cause;
  int         m_run;

  task automatic model_step();
    logic       tk, src, lnk, stl, abt, fire, accept;
    logic [7:0] tgt, pcn, n_sepc;
    logic       n_trap;
    logic [1:0] n_cause;
    case (funct3)
      3'd0: tk = Zero;
      3'd1: tk = !Zero;
      3'd4: tk = Neg;
      3'd5: tk = !Neg;
      3'd6: tk = Carry;
      3'd7: tk = !Carry;
      default: tk = 1'b0;
    endcase
    src = 1'b1;
    if (ret)                tgt = m_sepc;
    else if (jr)            tgt = 8'(PCReg + IMM) & 8'hFE;
    else if (ju || (Branch && tk)) tgt = 8'(m_pc + IMM);
    else begin tgt = 8'(m_pc + 8'd4); src = 1'b0; end
    fire   = busy && (m_run + 1 == TO);
    accept = !busy && !m_trap && (m_pend || interrupt);
    n_sepc = m_sepc; n_trap = m_trap; n_cause = m_cause;
    lnk = 1'b0; stl = 1'b0; abt = 1'b0;
    if (fire) begin
      pcn = 8'h80; src = 1'b0; abt = 1'b1;
      n_sepc = m_pc; n_trap = 1'b1; n_cause = 2'd2;
    end else if (busy) begin
      pcn = m_pc; src = 1'b0; stl = 1'b1;
    end else begin
      lnk = ju || jr;
      if (accept) begin
        pcn = 8'h80; n_sepc = tgt; n_trap = 1'b1; n_cause = 2'd1;
      end else begin
        pcn = tgt;
        if (ret) begin n_trap = 1'b0; n_cause = 2'd0; end
      end
    end
    chk("rnd_pc", 32'(pc), 32'(m_pc));
    chk("rnd_pclink", 32'(pclink), 32'(8'(m_pc + 8'd4)));
    chk("rnd_pc_next", 32'(pc_next), 32'(pcn));
    chk("rnd_flags", 32'({link, PCSrc, stall, abort}), 32'({lnk, src, stl, abt}));
    chk("rnd_state", 32'({sepc, in_trap, cause}), 32'({m_sepc, m_trap, m_cause}));
    m_run   = busy && !fire ? m_run + 1 : 0;
    m_pend  = accept ? 1'b0 : (m_pend || interrupt);
    m_pc    = pcn;
    m_sepc  = n_sepc;
    m_trap  = n_trap;
    m_cause = n_cause;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cur_pc;
    logic       busy_r;

    //        req      f3    imm    pcreg  flg     ctl    pcn    out      pc     sepc   trap  cause
    vt[0]  = '{4'b0000, 3'd0, 8'h00, 8'h00, 3'b000, 2'b00, 8'h04, 4'b0000, 8'h04, 8'h00, 1'b0, 2'd0};
    vt[1]  = '{4'b0000, 3'd0, 8'h00, 8'h00, 3'b000, 2'b00, 8'h08, 4'b0000, 8'h08, 8'h00, 1'b0, 2'd0};
    vt[2]  = '{4'b0000, 3'd0, 8'h00, 8'h00, 3'b000, 2'b00, 8'h0C, 4'b0000, 8'h0C, 8'h00, 1'b0, 2'd0};
    vt[3]  = '{4'b0100, 3'd0, 8'hF0, 8'h00, 3'b000, 2'b00, 8'hFC, 4'b1100, 8'hFC, 8'h00, 1'b0, 2'd0};
    vt[4]  = '{4'b0000, 3'd0, 8'h00, 8'h00, 3'b000, 2'b00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 2'd0};
    vt[5]  = '{4'b0000, 3'd0, 8'h00, 8'h00, 3'b000, 2'b00, 8'h04, 4'b0000, 8'h04, 8'h00, 1'b0, 2'd0};
    vt[6]  = '{4'b0000, 3'd0, 8'h00, 8'h00, 3'b000, 2'b00, 8'h08, 4'b0000, 8'h08, 8'h00, 1'b0, 2'd0};
    vt[7]  = '{4'b1000, 3'd5, 8'hF8, 8'h00, 3'b000, 2'b00, 8'h00, 4'b0100, 8'h00, 8'h00, 1'b0, 2'd0};
    vt[8]  = '{4'b1000, 3'd0, 8'h40, 8'h00, 3'b000, 2'b00, 8'h04, 4'b0000, 8'h04, 8'h00, 1'b0, 2'd0};
    vt[9]  = '{4'b0010, 3'd0, 8'h02, 8'h23, 3'b000, 2'b00, 8'h24, 4'b1100, 8'h24, 8'h00, 1'b0, 2'd0};
    vt[10] = '{4'b0100, 3'd0, 8'hE4, 8'h00, 3'b000, 2'b00, 8'h08, 4'b1100, 8'h08, 8'h00, 1'b0, 2'd0};
    vt[11] = '{4'b0100, 3'd0, 8'h10, 8'h00, 3'b000, 2'b01, 8'h80, 4'b1100, 8'h80, 8'h18, 1'b1, 2'd1};
    vt[12] = '{4'b0000, 3'd0, 8'h00, 8'h00, 3'b000, 2'b01, 8'h84, 4'b0000, 8'h84, 8'h18, 1'b1, 2'd1};
    vt[13] = '{4'b0001, 3'd0, 8'h00, 8'h00, 3'b000, 2'b00, 8'h18, 4'b0100, 8'h18, 8'h18, 1'b0, 2'd0};
    vt[14] = '{4'b0000, 3'd0, 8'h00, 8'h00, 3'b000, 2'b00, 8'h80, 4'b0000, 8'h80, 8'h1C, 1'b1, 2'd1};
    vt[15] = '{4'b0001, 3'd0, 8'h00, 8'h00, 3'b000, 2'b00, 8'h1C, 4'b0100, 8'h1C, 8'h1C, 1'b0, 2'd0};
    vt[16] = '{4'b0000, 3'd0, 8'h00, 8'h00, 3'b000, 2'b00, 8'h20, 4'b0000, 8'h20, 8'h1C, 1'b0, 2'd0};
    vt[17] = '{4'b0100, 3'd0, 8'h40, 8'h00, 3'b000, 2'b10, 8'h20, 4'b0010, 8'h20, 8'h1C, 1'b0, 2'd0};
    vt[18] = '{4'b0100, 3'd0, 8'h40, 8'h00, 3'b000, 2'b10, 8'h20, 4'b0010, 8'h20, 8'h1C, 1'b0, 2'd0};
    vt[19] = '{4'b0100, 3'd0, 8'h40, 8'h00, 3'b000, 2'b10, 8'h20, 4'b0010, 8'h20, 8'h1C, 1'b0, 2'd0};
    vt[20] = '{4'b0000, 3'd0, 8'h00, 8'h00, 3'b000, 2'b00, 8'h24, 4'b0000, 8'h24, 8'h1C, 1'b0, 2'd0};
    vt[21] = '{4'b0100, 3'd0, 8'hFC, 8'h00, 3'b000, 2'b00, 8'h20, 4'b1100, 8'h20, 8'h1C, 1'b0, 2'd0};
    vt[22] = '{4'b0000, 3'd0, 8'h00, 8'h00, 3'b000, 2'b10, 8'h20, 4'b0010, 8'h20, 8'h1C, 1'b0, 2'd0};
    vt[23] = '{4'b0000, 3'd0, 8'h00, 8'h00, 3'b000, 2'b10, 8'h20, 4'b0010, 8'h20, 8'h1C, 1'b0, 2'd0};
    vt[24] = '{4'b0000, 3'd0, 8'h00, 8'h00, 3'b000, 2'b10, 8'h20, 4'b0010, 8'h20, 8'h1C, 1'b0, 2'd0};
    vt[25] = '{4'b0100, 3'd0, 8'h08, 8'h00, 3'b000, 2'b10, 8'h80, 4'b0001, 8'h80, 8'h20, 1'b1, 2'd2};
    vt[26] = '{4'b0000, 3'd0, 8'h00, 8'h00, 3'b000, 2'b00, 8'h84, 4'b0000, 8'h84, 8'h20, 1'b1, 2'd2};
    vt[27] = '{4'b0001, 3'd0, 8'h00, 8'h00, 3'b000, 2'b00, 8'h20, 4'b0100, 8'h20, 8'h20, 1'b0, 2'd0};
    vt[28] = '{4'b1000, 3'd6, 8'h10, 8'h00, 3'b001, 2'b00, 8'h30, 4'b0100, 8'h30, 8'h20, 1'b0, 2'd0};
    vt[29] = '{4'b1000, 3'd3, 8'h10, 8'h00, 3'b111, 2'b00, 8'h34, 4'b0000, 8'h34, 8'h20, 1'b0, 2'd0};
    vt[30] = '{4'b1111, 3'd0, 8'h10, 8'h40, 3'b100, 2'b00, 8'h20, 4'b1100, 8'h20, 8'h20, 1'b0, 2'd0};

    // Reset with requests present: combinational strobes must stay quiet
    reset = 1'b0;
    drive(4'b0110, 3'd0, 8'h10, 8'h30, 3'b000, 2'b01);
    repeat (2) @(negedge clock);
    #1;
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_pc_next", 32'(pc_next), 32'h00);
    chk("rst_strobes", 32'({link, PCSrc, abort}), 32'h0);
    chk("rst_state", 32'({sepc, in_trap, cause}), 32'h0);
    @(negedge clock);
    drive(4'b0000, 3'd0, 8'h00, 8'h00, 3'b000, 2'b00);
    reset = 1'b1;

    // Directed vector table
    cur_pc = 8'h00;
    for (int i = 0; i <= 30; i++) begin
      drive(vt[i].req, vt[i].f3, vt[i].imm, vt[i].pcreg, vt[i].flg, vt[i].ctl);
      #1;
      chk($sformatf("v%0d_pc", i), 32'(pc), 32'(cur_pc));
      chk($sformatf("v%0d_pclink", i), 32'(pclink), 32'(8'(cur_pc + 8'd4)));
      chk($sformatf("v%0d_pc_next", i), 32'(pc_next), 32'(vt[i].e_pcn));
      chk($sformatf("v%0d_flags", i), 32'({link, PCSrc, stall, abort}), 32'(vt[i].e_out));
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_pc_after", i), 32'(pc), 32'(vt[i].e_pc));
      chk($sformatf("v%0d_sepc", i), 32'(sepc), 32'(vt[i].e_sepc));
      chk($sformatf("v%0d_trap", i), 32'({in_trap, cause}), 32'({vt[i].e_trap, vt[i].e_cause}));
      cur_pc = vt[i].e_pc;
      @(negedge clock);
    end

    // Reset asserted in the middle of a stall discards the busy count
    drive(4'b0000, 3'd0, 8'h00, 8'h00, 3'b000, 2'b10);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_pc", 32'(pc), 32'h00);
    chk("mid_rst_pc_next", 32'(pc_next), 32'h00);
    chk("mid_rst_sepc", 32'(sepc), 32'h00);
    @(negedge clock);
    drive(4'b0000, 3'd0, 8'h00, 8'h00, 3'b000, 2'b00);
    #1;
    reset = 1'b1;
    #1;
    chk("post_rst_stall", 32'(stall), 32'h0);
    chk("post_rst_pc_next", 32'(pc_next), 32'h04);
    @(posedge clock);
    #1;
    chk("post_rst_pc", 32'(pc), 32'h04);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive(4'b0000, 3'd0, 8'h00, 8'h00, 3'b000, 2'b10);
      #1;
      chk($sformatf("post_rst_busy%0d", i), 32'({stall, abort, pc_next}), 32'({1'b1, 1'b0, 8'h04}));
    end
    @(negedge clock);
    drive(4'b0000, 3'd0, 8'h00, 8'h00, 3'b000, 2'b00);
    #1;
    chk("post_rst_resume", 32'(pc_next), 32'h08);
    @(posedge clock);
    @(negedge clock);

    // Randomized traffic against the model
    m_pc = 8'h08; m_sepc = 8'h00; m_trap = 1'b0; m_pend = 1'b0; m_cause = 2'd0; m_run = 0;
    busy_r = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) busy_r = ~busy_r;
      drive({$urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0},
            3'($urandom), 8'($urandom), 8'($urandom), 3'($urandom),
            {busy_r, $urandom_range(0, 9) == 0});
      #1;
      model_step();
      @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
